rc4_sequencer: RTL and testbench
================================

RC4_SEQUENCER -- requirements
Module: rc4_sequencer

Interface
REQ-001 Parameter KEY_W, default 24: secret key width.
REQ-002 Parameter KEY_MAX, default 24'h3FFFFF: last key in the search space.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  single-cycle pulse; begins a key search at key_start.
REQ-006 abort  in  1  single-cycle pulse; terminates the search.
REQ-007 key_start  in  KEY_W  first key to try; sampled on accepted start.
REQ-008 init_done / shuffle_done / decrypt_done  in  1 each  single-cycle completion pulses from the stage machines.
REQ-009 decrypt_valid  in  1  plaintext-acceptable flag; meaningful only in the decrypt_done cycle.
REQ-010 start_init / start_shuffle / start_decrypt  out  1 each  level stage enables; also drive the memory handler's stage select.
REQ-011 secret_key  out  KEY_W  key currently under test, or the key found.
REQ-012 busy  out  1  high in INIT, SHUFFLE, DECRYPT and NEXT_KEY.
REQ-013 found / fail  out  1 each  sticky result flags.

Function
REQ-014 States: IDLE, INIT, SHUFFLE, DECRYPT, NEXT_KEY, FOUND, FAIL. All outputs are registered.
REQ-015 At most one start_* is high in any cycle. start_init is high only in INIT, start_shuffle only in SHUFFLE, start_decrypt only in DECRYPT.
REQ-016 IDLE, FOUND or FAIL + start: load secret_key <= key_start, clear found and fail, go to INIT next cycle.
REQ-017 If key_start > KEY_MAX at start: go to FAIL instead; no start_* is asserted.
REQ-018 INIT + init_done -> SHUFFLE. SHUFFLE + shuffle_done -> DECRYPT.
REQ-019 DECRYPT + decrypt_done + decrypt_valid -> FOUND; found=1; secret_key is held.
REQ-020 DECRYPT + decrypt_done + !decrypt_valid -> NEXT_KEY.
REQ-021 NEXT_KEY lasts exactly one cycle with all start_* low, so each stage sees a fresh rising edge.
REQ-022 In NEXT_KEY: if secret_key == KEY_MAX, go to FAIL with fail=1 and secret_key unchanged (no wrap); otherwise secret_key += 1 (width KEY_W) and go to INIT.
REQ-023 Latency: a stage done pulse in cycle N gives the next start_* high in cycle N+1. A failed key gives start_init high in cycle N+2.
REQ-024 Done pulses from a stage that is not the active one are ignored.
REQ-025 start while busy is ignored.
REQ-026 abort in any state -> IDLE next cycle; all start_* low; found and fail cleared; secret_key held.
REQ-027 abort wins over a simultaneous done pulse or start.
REQ-028 found and fail are never high together.

Reset
REQ-029 reset forces IDLE, start_*=0, busy=0, found=0, fail=0, secret_key=0, immediately and asynchronously.
REQ-030 A reset in the middle of a search discards it; operation resumes only on a new start after reset deasserts.

Structure
REQ-031 Package rc4_pkg holds the state enum, KEY_W, and KEY_MAX.
REQ-032 One sub-module, rc4_key_counter, is natural: load, increment, and at-max flag.
REQ-033 The FSM and output registers stay in rc4_sequencer.

Verification
REQ-034 start with key_start=0; first decrypt_done has valid=1 -> start_init, start_shuffle, start_decrypt each high in turn; found=1; secret_key=0.
REQ-035 key_start=5; decrypts return valid=0, 0, then 1 -> secret_key shows 5, 6, 7; found=1 with secret_key=7; one all-low cycle before each re-INIT.
REQ-036 key_start=KEY_MAX with valid=0 -> fail=1, secret_key=24'h3FFFFF, no further start_init.
REQ-037 key_start=24'h400000 -> fail=1 one cycle after start; start_* never asserted.
REQ-038 shuffle_done pulsed during INIT -> no state change. abort coincident with decrypt_done -> IDLE, found=0.
REQ-039 reset asserted during SHUFFLE -> all outputs 0 without waiting for a clock edge; a later start behaves as REQ-034.

Source files
------------

// File: rtl/rc4_pkg.sv
// RC4 key-search sequencer: shared key-space constants and FSM state encoding.
// Imported by rc4_key_counter and rc4_sequencer.
package rc4_pkg;

  localparam int KEY_W = 24;
  localparam logic [KEY_W-1:0] KEY_MAX = 24'h3FFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_SHUFFLE,
    ST_DECRYPT,
    ST_NEXT_KEY,
    ST_FOUND,
    ST_FAIL
  } state_e;

endpackage

// File: rtl/rc4_key_counter.sv
// Candidate-key register for the RC4 key search: load, saturating increment,
// and range flags.
// Ports:
//   clk, reset : clock, async active-high reset (key -> 0)
//   load       : capture load_val (has priority over inc)
//   load_val   : first key of a search
//   inc        : step to the next key; never wraps past KEY_MAX
//   key        : registered current key
//   at_max     : key == KEY_MAX
//   load_over  : load_val lies outside the search space
module rc4_key_counter #(
  parameter int KEY_W = rc4_pkg::KEY_W,
  parameter logic [KEY_W-1:0] KEY_MAX = rc4_pkg::KEY_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [KEY_W-1:0] load_val,
  input  logic             inc,
  output logic [KEY_W-1:0] key,
  output logic             at_max,
  output logic             load_over
);

  import rc4_pkg::*;

  logic [KEY_W-1:0] key_q;
  logic [KEY_W-1:0] key_d;

  assign at_max    = (key_q == KEY_MAX);
  assign load_over = (load_val > KEY_MAX);
  assign key       = key_q;

  always_comb begin
    key_d = key_q;
    if (load) begin
      key_d = load_val;
    end else if (inc && !at_max) begin
      key_d = key_q + KEY_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q <= '0;
    end else begin
      key_q <= key_d;
    end
  end

endmodule

// File: rtl/rc4_sequencer.sv
// RC4 brute-force key-search sequencer: steps each key through the
// init/shuffle/decrypt stage machines and reports found or exhausted.
// Ports:
//   clk, reset        : clock, async active-high reset
//   start, abort      : single-cycle commands (abort has priority)
//   key_start         : first key, sampled on an accepted start
//   init_done, shuffle_done, decrypt_done : stage completion pulses
//   decrypt_valid     : plaintext acceptable, qualified by decrypt_done
//   start_init, start_shuffle, start_decrypt : level stage enables
//   secret_key        : key under test / key found
//   busy, found, fail : status; found and fail are sticky
module rc4_sequencer #(
  parameter int KEY_W = rc4_pkg::KEY_W,
  parameter logic [KEY_W-1:0] KEY_MAX = rc4_pkg::KEY_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [KEY_W-1:0] key_start,
  input  logic             init_done,
  input  logic             shuffle_done,
  input  logic             decrypt_done,
  input  logic             decrypt_valid,
  output logic             start_init,
  output logic             start_shuffle,
  output logic             start_decrypt,
  output logic [KEY_W-1:0] secret_key,
  output logic             busy,
  output logic             found,
  output logic             fail
);

  import rc4_pkg::*;

  state_e state_q;
  state_e state_d;

  logic key_load;
  logic key_inc;
  logic key_at_max;
  logic key_over;

  logic start_init_q;
  logic start_init_d;
  logic start_shuffle_q;
  logic start_shuffle_d;
  logic start_decrypt_q;
  logic start_decrypt_d;
  logic busy_q;
  logic busy_d;
  logic found_q;
  logic found_d;
  logic fail_q;
  logic fail_d;

  rc4_key_counter #(
    .KEY_W   (KEY_W),
    .KEY_MAX (KEY_MAX)
  ) u_key (
    .clk       (clk),
    .reset     (reset),
    .load      (key_load),
    .load_val  (key_start),
    .inc       (key_inc),
    .key       (secret_key),
    .at_max    (key_at_max),
    .load_over (key_over)
  );

  always_comb begin
    state_d  = state_q;
    key_load = 1'b0;
    key_inc  = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_FOUND, ST_FAIL: begin
          if (start) begin
            key_load = 1'b1;
            state_d  = key_over ? ST_FAIL : ST_INIT;
          end
        end
        ST_INIT: begin
          if (init_done) state_d = ST_SHUFFLE;
        end
        ST_SHUFFLE: begin
          if (shuffle_done) state_d = ST_DECRYPT;
        end
        ST_DECRYPT: begin
          if (decrypt_done) begin
            state_d = decrypt_valid ? ST_FOUND : ST_NEXT_KEY;
          end
        end
        ST_NEXT_KEY: begin
          // Last key exhausted: stop without wrapping.
          if (key_at_max) begin
            state_d = ST_FAIL;
          end else begin
            key_inc = 1'b1;
            state_d = ST_INIT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from the next state so they are registered
  // alongside the state itself.
  always_comb begin
    start_init_d    = (state_d == ST_INIT);
    start_shuffle_d = (state_d == ST_SHUFFLE);
    start_decrypt_d = (state_d == ST_DECRYPT);
    busy_d          = (state_d == ST_INIT) ||
                      (state_d == ST_SHUFFLE) ||
                      (state_d == ST_DECRYPT) ||
                      (state_d == ST_NEXT_KEY);
    found_d         = (state_d == ST_FOUND);
    fail_d          = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      start_init_q    <= 1'b0;
      start_shuffle_q <= 1'b0;
      start_decrypt_q <= 1'b0;
      busy_q          <= 1'b0;
      found_q         <= 1'b0;
      fail_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      start_init_q    <= start_init_d;
      start_shuffle_q <= start_shuffle_d;
      start_decrypt_q <= start_decrypt_d;
      busy_q          <= busy_d;
      found_q         <= found_d;
      fail_q          <= fail_d;
    end
  end

  assign start_init    = start_init_q;
  assign start_shuffle = start_shuffle_q;
  assign start_decrypt = start_decrypt_q;
  assign busy          = busy_q;
  assign found         = found_q;
  assign fail          = fail_q;

endmodule

// File: tb/tb_rc4_sequencer.sv
// Randomized self-checking bench for rc4_sequencer against a
// key-sequence reference model.
module tb_rc4_sequencer;

  localparam logic [23:0] KMAX = 24'h3FFFFF;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [23:0] key_start;
  logic        init_done;
  logic        shuffle_done;
  logic        decrypt_done;
  logic        decrypt_valid;
  logic        start_init;
  logic        start_shuffle;
  logic        start_decrypt;
  logic [23:0] secret_key;
  logic        busy;
  logic        found;
  logic        fail;

  int nerr = 0;
  int nchk = 0;

  rc4_sequencer #(
    .KEY_W   (24),
    .KEY_MAX (KMAX)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .key_start     (key_start),
    .init_done     (init_done),
    .shuffle_done  (shuffle_done),
    .decrypt_done  (decrypt_done),
    .decrypt_valid (decrypt_valid),
    .start_init    (start_init),
    .start_shuffle (start_shuffle),
    .start_decrypt (start_decrypt),
    .secret_key    (secret_key),
    .busy          (busy),
    .found         (found),
    .fail          (fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] stv();
    return {29'd0, start_init, start_shuffle, start_decrypt};
  endfunction

  task automatic clr_in();
    start         = 1'b0;
    abort         = 1'b0;
    init_done     = 1'b0;
    shuffle_done  = 1'b0;
    decrypt_done  = 1'b0;
    decrypt_valid = 1'b0;
  endtask

  // Idle in a stage while throwing ignorable stimulus at the DUT:
  // done pulses of other stages and start requests while busy.
  task automatic stay(input int d, input logic [2:0] mask,
                      input logic [23:0] key);
    for (int i = 0; i < d; i++) begin
      init_done     = !mask[2] && ($urandom_range(0, 1) == 1);
      shuffle_done  = !mask[1] && ($urandom_range(0, 1) == 1);
      decrypt_done  = !mask[0] && ($urandom_range(0, 1) == 1);
      decrypt_valid = ($urandom_range(0, 1) == 1);
      start         = ($urandom_range(0, 1) == 1);
      key_start     = 24'($urandom());
      tick();
      clr_in();
      chk("hold_starts", stv(), {29'd0, mask});
      chk("hold_key", {8'd0, secret_key}, {8'd0, key});
      chk("hold_busy", {31'd0, busy}, 32'd1);
    end
  endtask

  // Reference: keys tried are ks, ks+1, ... ; search ends with found
  // on attempt nbad, or fail once KMAX has been rejected.
  task automatic run_search(input logic [23:0] ks, input int nbad);
    logic [23:0] key;
    key       = ks;
    key_start = ks;
    start     = 1'b1;
    tick();
    clr_in();
    if (ks > KMAX) begin
      chk("over_fail", {31'd0, fail}, 32'd1);
      chk("over_found", {31'd0, found}, 32'd0);
      chk("over_starts", stv(), 32'd0);
      chk("over_busy", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("over_quiet", stv(), 32'd0);
        chk("over_sticky", {31'd0, fail}, 32'd1);
      end
      return;
    end
    for (int i = 0; i <= nbad; i++) begin
      chk("init_on", stv(), 32'd4);
      chk("init_key", {8'd0, secret_key}, {8'd0, key});
      chk("init_busy", {31'd0, busy}, 32'd1);
      chk("init_flags", {30'd0, found, fail}, 32'd0);
      stay($urandom_range(0, 3), 3'b100, key);
      init_done = 1'b1;
      tick();
      clr_in();
      chk("shuf_on", stv(), 32'd2);
      stay($urandom_range(0, 3), 3'b010, key);
      shuffle_done = 1'b1;
      tick();
      clr_in();
      chk("decr_on", stv(), 32'd1);
      stay($urandom_range(0, 3), 3'b001, key);
      decrypt_done  = 1'b1;
      decrypt_valid = (i == nbad);
      tick();
      clr_in();
      if (i == nbad) begin
        chk("found", {31'd0, found}, 32'd1);
        chk("found_fail", {31'd0, fail}, 32'd0);
        chk("found_busy", {31'd0, busy}, 32'd0);
        chk("found_starts", stv(), 32'd0);
        chk("found_key", {8'd0, secret_key}, {8'd0, key});
        tick();
        chk("found_sticky", {31'd0, found}, 32'd1);
        return;
      end
      chk("next_low", stv(), 32'd0);
      chk("next_busy", {31'd0, busy}, 32'd1);
      tick();
      if (key == KMAX) begin
        chk("exh_fail", {31'd0, fail}, 32'd1);
        chk("exh_found", {31'd0, found}, 32'd0);
        chk("exh_key", {8'd0, secret_key}, {8'd0, KMAX});
        chk("exh_busy", {31'd0, busy}, 32'd0);
        for (int j = 0; j < 2; j++) begin
          chk("exh_quiet", stv(), 32'd0);
          tick();
        end
        return;
      end
      key = key + 24'd1;
    end
  endtask

  initial begin
    reset     = 1'b1;
    key_start = '0;
    clr_in();
    #1;
    chk("rst_starts", stv(), 32'd0);
    chk("rst_flags", {29'd0, busy, found, fail}, 32'd0);
    chk("rst_key", {8'd0, secret_key}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    run_search(24'd0, 0);
    run_search(24'd5, 2);
    run_search(KMAX, 5);
    run_search(KMAX - 24'd1, 5);
    run_search(24'h400000, 0);

    // abort clears a sticky fail
    abort = 1'b1;
    tick();
    clr_in();
    chk("abort_fail", {31'd0, fail}, 32'd0);
    chk("abort_idle", {31'd0, busy}, 32'd0);

    // abort beats a simultaneous good decrypt
    key_start = 24'h123;
    start = 1'b1;
    tick();
    clr_in();
    init_done = 1'b1;
    tick();
    clr_in();
    shuffle_done = 1'b1;
    tick();
    clr_in();
    chk("pre_abort", stv(), 32'd1);
    abort = 1'b1;
    decrypt_done = 1'b1;
    decrypt_valid = 1'b1;
    tick();
    clr_in();
    chk("abd_found", {31'd0, found}, 32'd0);
    chk("abd_busy", {31'd0, busy}, 32'd0);
    chk("abd_starts", stv(), 32'd0);
    chk("abd_key", {8'd0, secret_key}, 32'h123);

    // abort beats start
    abort = 1'b1;
    start = 1'b1;
    key_start = 24'h9;
    tick();
    clr_in();
    chk("abs_busy", {31'd0, busy}, 32'd0);
    chk("abs_starts", stv(), 32'd0);

    // asynchronous reset in SHUFFLE
    key_start = 24'h77;
    start = 1'b1;
    tick();
    clr_in();
    init_done = 1'b1;
    tick();
    clr_in();
    chk("pre_rst", stv(), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_starts", stv(), 32'd0);
    chk("arst_flags", {29'd0, busy, found, fail}, 32'd0);
    chk("arst_key", {8'd0, secret_key}, 32'd0);
    tick();
    reset = 1'b0;
    shuffle_done = 1'b1;
    tick();
    clr_in();
    chk("post_rst_idle", {31'd0, busy}, 32'd0);
    run_search(24'd0, 0);

    for (int n = 0; n < 25; n++) begin
      logic [23:0] ks;
      int sel;
      sel = $urandom_range(0, 3);
      if (sel == 0) ks = 24'($urandom_range(0, 32'h3FFFFF));
      else if (sel == 1) ks = KMAX - 24'($urandom_range(0, 3));
      else if (sel == 2) ks = 24'($urandom_range(32'h400000, 32'hFFFFFF));
      else ks = 24'($urandom_range(0, 20));
      run_search(ks, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
